// File: rtl/fp_sign_pkg.sv
// Shared types and helpers for the IEEE 754 sign-manipulation unit.
// Helpers take a 64-bit value so one function covers half, single and double.
package fp_sign_pkg;

    typedef enum logic [2:0] {
        OP_PASS  = 3'b000,
        OP_NEG   = 3'b001,
        OP_ABS   = 3'b010,
        OP_SGNJ  = 3'b011,
        OP_SGNJN = 3'b100,
        OP_SGNJX = 3'b101
    } sign_op_e;

    function automatic logic [63:0] exp_mask(input int exp_w, input int man_w);
        return ((64'd1 << exp_w) - 64'd1) << man_w;
    endfunction

    function automatic logic is_nan(input logic [63:0] val, input int exp_w, input int man_w);
        logic [63:0] em;
        logic [63:0] mm;
        em = exp_mask(exp_w, man_w);
        mm = (64'd1 << man_w) - 64'd1;
        return ((val & em) == em) && ((val & mm) != 64'd0);
    endfunction

    // Positive sign, all-ones exponent, only the quiet bit set in the mantissa.
    function automatic logic [63:0] canon_nan(input int exp_w, input int man_w);
        return exp_mask(exp_w, man_w) | (64'd1 << (man_w - 1));
    endfunction

endpackage

// File: rtl/fp_sign_pipe_stage.sv
// One elastic register slice: holds a payload until downstream takes it,
// and accepts a new one in the same cycle when the current one leaves.
module fp_sign_pipe_stage #(
    parameter int DW = 34
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          up_valid,
    input  logic [DW-1:0] up_data,
    output logic          up_ready,
    output logic          dn_valid,
    output logic [DW-1:0] dn_data,
    input  logic          dn_ready
);

    logic          valid_r;
    logic [DW-1:0] data_r;

    // Slice can take new data when empty or when its contents are leaving.
    always_comb begin
        up_ready = !valid_r || dn_ready;
    end

    // Valid/data register; an empty upstream clears valid once data is taken.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_r <= 1'b0;
            data_r  <= '0;
        end else if (up_ready) begin
            valid_r <= up_valid;
            if (up_valid) begin
                data_r <= up_data;
            end
        end
    end

    assign dn_valid = valid_r;
    assign dn_data  = data_r;

endmodule

// File: rtl/fp_sign_unit.sv
// Pipelined IEEE 754 sign manipulation (pass/neg/abs/sign-injection).
// Define FP_SIGN_CANON_NAN_EN to replace NaN operands with the canonical quiet NaN.
module fp_sign_unit
    import fp_sign_pkg::*;
#(
    parameter int EXP_W       = 8,
    parameter int MAN_W       = 23,
    parameter int PIPE_STAGES = 1
) (
    input  logic                   clk,
    input  logic                   rst_n,
    input  logic                   in_valid,
    output logic                   in_ready,
    input  logic [2:0]             op,
    input  logic [EXP_W+MAN_W:0]   fp_a,
    input  logic [EXP_W+MAN_W:0]   fp_b,
    output logic                   out_valid,
    input  logic                   out_ready,
    output logic [EXP_W+MAN_W:0]   fp_r,
    output logic                   nan_flag,
    output logic                   illegal_op
);

    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int DW = W + 2;

    if (PIPE_STAGES < 1 || PIPE_STAGES > 3) begin : g_bad_stages
        $error("fp_sign_unit: PIPE_STAGES must be in 1..3");
    end

`ifdef FP_SIGN_CANON_NAN_EN
    localparam logic [63:0]  CANON_FULL = canon_nan(EXP_W, MAN_W);
    localparam logic [W-1:0] CANON      = CANON_FULL[W-1:0];
`endif

    logic          sign_s;
    logic          illegal_s;
    logic          nan_s;
    logic [63:0]   a_ext_s;
    logic [W-1:0]  result_s;

    // Zero-extend fp_a so the shared width-agnostic NaN test can be used.
    always_comb begin
        a_ext_s          = 64'd0;
        a_ext_s[W-1:0]   = fp_a;
        nan_s            = is_nan(a_ext_s, EXP_W, MAN_W);
    end

    // Sign selection; illegal codes keep fp_a's own sign so fp_r == fp_a.
    always_comb begin
        sign_s    = fp_a[W-1];
        illegal_s = 1'b0;
        case (op)
            OP_PASS:  sign_s = fp_a[W-1];
            OP_NEG:   sign_s = ~fp_a[W-1];
            OP_ABS:   sign_s = 1'b0;
            OP_SGNJ:  sign_s = fp_b[W-1];
            OP_SGNJN: sign_s = ~fp_b[W-1];
            OP_SGNJX: sign_s = fp_a[W-1] ^ fp_b[W-1];
            default: begin
                sign_s    = fp_a[W-1];
                illegal_s = 1'b1;
            end
        endcase
    end

    // NaN operands bypass the sign logic; illegal ops return fp_a untouched.
    always_comb begin
        if (illegal_s) begin
            result_s = fp_a;
        end else if (nan_s) begin
`ifdef FP_SIGN_CANON_NAN_EN
            result_s = CANON;
`else
            result_s = fp_a;
`endif
        end else begin
            result_s = {sign_s, fp_a[W-2:0]};
        end
    end

    logic          stg_valid_s [0:PIPE_STAGES];
    logic [DW-1:0] stg_data_s  [0:PIPE_STAGES];
    logic          stg_ready_s [0:PIPE_STAGES];

    assign stg_valid_s[0]           = in_valid;
    assign stg_data_s[0]            = {result_s, nan_s, illegal_s};
    assign stg_ready_s[PIPE_STAGES] = out_ready;
    assign in_ready                 = stg_ready_s[0];

    for (genvar i = 0; i < PIPE_STAGES; i++) begin : g_stage
        fp_sign_pipe_stage #(.DW(DW)) u_stage (
            .clk      (clk),
            .rst_n    (rst_n),
            .up_valid (stg_valid_s[i]),
            .up_data  (stg_data_s[i]),
            .up_ready (stg_ready_s[i]),
            .dn_valid (stg_valid_s[i+1]),
            .dn_data  (stg_data_s[i+1]),
            .dn_ready (stg_ready_s[i+1])
        );
    end

    assign out_valid                    = stg_valid_s[PIPE_STAGES];
    assign {fp_r, nan_flag, illegal_op} = stg_data_s[PIPE_STAGES];

endmodule

// File: tb/tb_fp_sign_unit.sv
// Directed bench for fp_sign_unit: single/half precision vectors with
// PIPE_STAGES=1, plus backpressure and mid-stall reset on PIPE_STAGES=2.
module tb_fp_sign_unit;
    import fp_sign_pkg::*;

`ifdef FP_SIGN_CANON_NAN_EN
    localparam bit CANON = 1'b1;
`else
    localparam bit CANON = 1'b0;
`endif

    logic        clk;
    logic        rst_n;
    logic        drv_valid;
    logic        drv_oready;
    logic [2:0]  drv_op;
    logic [31:0] drv_a;
    logic [31:0] drv_b;
    int          sel;

    logic        sp_in_ready, sp_out_valid, sp_nan, sp_ill;
    logic [31:0] sp_r;
    logic        hp_in_ready, hp_out_valid, hp_nan, hp_ill;
    logic [15:0] hp_r;
    logic        p2_in_ready, p2_out_valid, p2_nan, p2_ill;
    logic [31:0] p2_r;

    int passed = 0;
    int total  = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    fp_sign_unit #(.EXP_W(8), .MAN_W(23), .PIPE_STAGES(1)) u_sp (
        .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 0), .in_ready(sp_in_ready),
        .op(drv_op), .fp_a(drv_a), .fp_b(drv_b), .out_valid(sp_out_valid),
        .out_ready(drv_oready), .fp_r(sp_r), .nan_flag(sp_nan), .illegal_op(sp_ill));

    fp_sign_unit #(.EXP_W(5), .MAN_W(10), .PIPE_STAGES(1)) u_hp (
        .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 1), .in_ready(hp_in_ready),
        .op(drv_op), .fp_a(drv_a[15:0]), .fp_b(drv_b[15:0]), .out_valid(hp_out_valid),
        .out_ready(drv_oready), .fp_r(hp_r), .nan_flag(hp_nan), .illegal_op(hp_ill));

    fp_sign_unit #(.EXP_W(8), .MAN_W(23), .PIPE_STAGES(2)) u_p2 (
        .clk(clk), .rst_n(rst_n), .in_valid(drv_valid && sel == 2), .in_ready(p2_in_ready),
        .op(drv_op), .fp_a(drv_a), .fp_b(drv_b), .out_valid(p2_out_valid),
        .out_ready(drv_oready), .fp_r(p2_r), .nan_flag(p2_nan), .illegal_op(p2_ill));

    logic        v_in_ready, v_out_valid, v_nan, v_ill;
    logic [31:0] v_r;

    always_comb begin
        case (sel)
            1: begin
                v_in_ready = hp_in_ready; v_out_valid = hp_out_valid;
                v_nan = hp_nan; v_ill = hp_ill; v_r = {16'h0000, hp_r};
            end
            2: begin
                v_in_ready = p2_in_ready; v_out_valid = p2_out_valid;
                v_nan = p2_nan; v_ill = p2_ill; v_r = p2_r;
            end
            default: begin
                v_in_ready = sp_in_ready; v_out_valid = sp_out_valid;
                v_nan = sp_nan; v_ill = sp_ill; v_r = sp_r;
            end
        endcase
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) begin
            passed++;
        end else begin
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    // One transaction with out_ready high; measures cycles from accept to out_valid.
    task automatic run_txn(input string name, input int exp_lat, input logic [2:0] op,
                           input logic [31:0] a, input logic [31:0] b,
                           input logic [31:0] exp_r, input logic exp_nan, input logic exp_ill);
        int lat;
        lat = 99;
        @(negedge clk);
        drv_op = op; drv_a = a; drv_b = b; drv_valid = 1'b1; drv_oready = 1'b1;
        #1;
        chk({name, "_in_ready"}, 32'(v_in_ready), 32'd1);
        for (int k = 1; k <= 8; k++) begin
            @(posedge clk);
            @(negedge clk);
            drv_valid = 1'b0;
            if (v_out_valid) begin
                lat = k;
                break;
            end
        end
        chk({name, "_latency"}, 32'(lat), 32'(exp_lat));
        chk({name, "_fp_r"}, v_r, exp_r);
        chk({name, "_nan"}, 32'(v_nan), 32'(exp_nan));
        chk({name, "_ill"}, 32'(v_ill), 32'(exp_ill));
    endtask

    typedef struct {
        string       name;
        int          sel;
        logic [2:0]  op;
        logic [31:0] a;
        logic [31:0] b;
        logic [31:0] r;
        logic        nan;
        logic        ill;
    } vec_t;

    vec_t vecs [16];

    initial begin
        int sent;
        int got;

        vecs[0]  = '{"neg_one",     0, OP_NEG,   32'h3F800000, 32'h0, 32'hBF800000, 1'b0, 1'b0};
        vecs[1]  = '{"neg_qnan",    0, OP_NEG,   32'h7FC00001, 32'h0,
                     CANON ? 32'h7FC00000 : 32'h7FC00001, 1'b1, 1'b0};
        vecs[2]  = '{"sgnjx",       0, OP_SGNJX, 32'hC0000000, 32'h80000000, 32'h40000000, 1'b0, 1'b0};
        vecs[3]  = '{"sgnjn_inf",   0, OP_SGNJN, 32'hFF800000, 32'h00000000, 32'hFF800000, 1'b0, 1'b0};
        vecs[4]  = '{"pass_negz",   0, OP_PASS,  32'h80000000, 32'h0, 32'h80000000, 1'b0, 1'b0};
        vecs[5]  = '{"abs_inf",     0, OP_ABS,   32'hFF800000, 32'h0, 32'h7F800000, 1'b0, 1'b0};
        vecs[6]  = '{"sgnj_neg",    0, OP_SGNJ,  32'h3F800000, 32'h80000000, 32'hBF800000, 1'b0, 1'b0};
        vecs[7]  = '{"sgnj_bnan",   0, OP_SGNJ,  32'hBF800000, 32'h7FC00000, 32'h3F800000, 1'b0, 1'b0};
        vecs[8]  = '{"abs_snan",    0, OP_ABS,   32'hFF800001, 32'h0,
                     CANON ? 32'h7FC00000 : 32'hFF800001, 1'b1, 1'b0};
        vecs[9]  = '{"illegal_110", 0, 3'b110,   32'h12345678, 32'hFFFFFFFF, 32'h12345678, 1'b0, 1'b1};
        vecs[10] = '{"sgnjx_pi",    0, OP_SGNJX, 32'h40490FDB, 32'hC0000000, 32'hC0490FDB, 1'b0, 1'b0};
        vecs[11] = '{"neg_zero",    0, OP_NEG,   32'h00000000, 32'h0, 32'h80000000, 1'b0, 1'b0};
        vecs[12] = '{"h_abs",       1, OP_ABS,   32'h0000BC00, 32'h0, 32'h00003C00, 1'b0, 1'b0};
        vecs[13] = '{"h_illegal",   1, 3'b111,   32'h0000BC00, 32'h0, 32'h0000BC00, 1'b0, 1'b1};
        vecs[14] = '{"h_neg_nan",   1, OP_NEG,   32'h00007E01, 32'h0,
                     CANON ? 32'h00007E00 : 32'h00007E01, 1'b1, 1'b0};
        vecs[15] = '{"h_sgnjn",     1, OP_SGNJN, 32'h00003C00, 32'h00003C00, 32'h0000BC00, 1'b0, 1'b0};

        rst_n = 1'b0; drv_valid = 1'b0; drv_oready = 1'b1;
        drv_op = 3'b000; drv_a = 32'h0; drv_b = 32'h0; sel = 0;
        #3;
        chk("rst_sp_out_valid", 32'(sp_out_valid), 32'd0);
        chk("rst_sp_fp_r", sp_r, 32'h0);
        chk("rst_sp_in_ready", 32'(sp_in_ready), 32'd1);
        chk("rst_p2_out_valid", 32'(p2_out_valid), 32'd0);
        chk("rst_hp_flags", {30'd0, hp_nan, hp_ill}, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 16; i++) begin
            sel = vecs[i].sel;
            run_txn(vecs[i].name, 1, vecs[i].op, vecs[i].a, vecs[i].b,
                    vecs[i].r, vecs[i].nan, vecs[i].ill);
        end

        // Six back-to-back NEGs into the 2-stage pipe, out_ready low in cycles 2..5.
        sel = 2; sent = 0; got = 0;
        @(negedge clk);
        for (int c = 0; c < 40 && got < 6; c++) begin
            @(negedge clk);
            drv_oready = !(c >= 2 && c <= 5);
            drv_valid  = (sent < 6);
            drv_op     = OP_NEG;
            drv_a      = 32'h3F800000 + 32'(sent);
            #1;
            if (c == 2) chk("stall_in_ready_c2", 32'(p2_in_ready), 32'd0);
            if (c == 5) chk("stall_in_ready_c5", 32'(p2_in_ready), 32'd0);
            if (c == 6) chk("release_in_ready_c6", 32'(p2_in_ready), 32'd1);
            if (c == 4) chk("stall_hold_fp_r", p2_r, 32'hBF800000);
            if (c == 4) chk("stall_hold_valid", 32'(p2_out_valid), 32'd1);
            if (p2_out_valid && drv_oready) begin
                chk($sformatf("stream_out%0d", got), p2_r, 32'hBF800000 + 32'(got));
                got++;
            end
            if (drv_valid && p2_in_ready) sent++;
        end
        chk("stream_count", 32'(got), 32'd6);
        @(negedge clk);
        drv_valid = 1'b0; drv_oready = 1'b1;
        @(negedge clk);
        @(negedge clk);
        chk("stream_no_extra", 32'(p2_out_valid), 32'd0);

        // Fill both stages under stall, then reset mid-stall.
        @(negedge clk);
        drv_oready = 1'b0; drv_valid = 1'b1; drv_op = OP_NEG; drv_a = 32'h40000000;
        @(negedge clk);
        drv_a = 32'h40400000;
        @(negedge clk);
        drv_valid = 1'b0;
        chk("prereset_full", {30'd0, p2_out_valid, p2_in_ready}, 32'd2);
        #2;
        rst_n = 1'b0;
        #1;
        chk("reset_out_valid", 32'(p2_out_valid), 32'd0);
        chk("reset_fp_r", p2_r, 32'h0);
        chk("reset_in_ready", 32'(p2_in_ready), 32'd1);
        @(negedge clk);
        rst_n = 1'b1; drv_oready = 1'b1;
        @(negedge clk);
        chk("postreset_empty", 32'(p2_out_valid), 32'd0);
        run_txn("postreset_neg", 2, OP_NEG, 32'h3F800000, 32'h0, 32'hBF800000, 1'b0, 1'b0);

        @(negedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/fp_sign_unit.md
Name: fp_sign_unit

Overview:
- Parametrised, pipelined IEEE 754 sign-manipulation unit. Format width is set by EXP_W/MAN_W (half, single or double).
- Operations: pass, negate, absolute value, and the three sign-injection variants (copysign, copysign-negated, sign-xor).
- NaN operands pass through with their representation preserved.
- Sits beside the add/sub datapath in fp_alu, where fp_sub and fp_msub use it for operand negation. Valid/ready handshakes on both sides.

Parameters:
- EXP_W, 8, exponent field width.
- MAN_W, 23, mantissa field width. Total width W = 1+EXP_W+MAN_W.
- PIPE_STAGES, 1, number of register stages; legal values 1..3. Any other value raises an elaboration error.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- in_valid  in  1  input transaction valid.
- in_ready  out  1  unit can accept an input this cycle.
- op  in  3  operation: 000 PASS, 001 NEG, 010 ABS, 011 SGNJ, 100 SGNJN, 101 SGNJX; 110/111 illegal.
- fp_a  in  W  primary operand.
- fp_b  in  W  sign-source operand (used by SGNJ/SGNJN/SGNJX only).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts the result.
- fp_r  out  W  result.
- nan_flag  out  1  fp_a was NaN (exp all ones, mantissa nonzero).
- illegal_op  out  1  op was 110/111.

Behaviour:
- Compute is combinational in front of stage 0. Result sign s for non-NaN fp_a:
  - PASS: a.s
  - NEG: ~a.s
  - ABS: 0
  - SGNJ: b.s
  - SGNJN: ~b.s
  - SGNJX: a.s^b.s
- Exponent and mantissa always equal fp_a[W-2:0].
- fp_a NaN (quiet or signalling): fp_r = fp_a unchanged for every op, and nan_flag=1. Infinities and zeros are not NaN; their sign is modified normally.
- fp_b NaN has no special effect; only its sign bit is used.
- Illegal op: fp_r = fp_a, illegal_op=1. The NaN rule still applies to nan_flag.
- Pipeline is elastic; each stage holds {valid, fp_r, nan_flag, illegal_op}.
  - stage_ready[i] = !valid[i] | stage_ready[i+1]; the last stage uses out_ready.
  - in_ready = stage_ready[0]; this is a combinational path from out_ready.
  - A stage loads when its upstream valid is high and stage_ready[i] is high.
  - A stage clears valid when its data is taken and nothing new arrives.
- Latency: exactly PIPE_STAGES cycles from input handshake to out_valid with no stall. Throughput: 1 per cycle.
- Backpressure: while out_ready=0, the stages fill. in_ready falls once all PIPE_STAGES stages are valid. No transaction is lost or duplicated, and order is preserved.
- Simultaneous accept and release on a full pipe: allowed; the pipe stays full and holds its data.
- out_valid, once high, stays high with stable fp_r/flags until out_ready=1.
- Reset (asynchronous, any time, including mid-stall): all valid bits, fp_r, nan_flag and illegal_op go to 0 immediately. in_ready=1 during and after reset. In-flight transactions are discarded.
- Data registers are reset; there are no X values on outputs.

Optional Feature:
- Macro FP_SIGN_CANON_NAN_EN.
  - Defined: when fp_a is NaN, fp_r = canonical quiet NaN {1'b0, all-ones exp, 1'b1, zeros}, and nan_flag=1.
  - Undefined: the NaN is passed through bit-exact, as described above.
- Handshake and latency are identical in both builds.

Decomposition:
- Package fp_sign_pkg holds:
  - typedef enum logic [2:0] sign_op_e (PASS, NEG, ABS, SGNJ, SGNJN, SGNJX);
  - function is_nan(EXP_W, MAN_W);
  - the canonical-NaN constant builder.
- Natural sub-module: fp_sign_pipe_stage, a single elastic register slice with a parametrised payload width, instantiated PIPE_STAGES times in a generate loop.
- The sign-logic core stays inline.

Test Plan:
- Single precision, NEG, fp_a=0x3F800000 -> fp_r=0xBF800000, nan_flag=0, out_valid exactly PIPE_STAGES cycles after accept.
- NaN preservation, NEG, fp_a=0x7FC00001:
  - without macro -> 0x7FC00001, nan_flag=1;
  - with FP_SIGN_CANON_NAN_EN -> 0x7FC00000.
- SGNJX, fp_a=0xC0000000, fp_b=0x80000000 -> 0x40000000. SGNJN, fp_a=0xFF800000, fp_b=0x00000000 -> 0xFF800000.
- Half precision (EXP_W=5, MAN_W=10): ABS 0xBC00 -> 0x3C00; op=3'b111 -> fp_r=fp_a, illegal_op=1.
- PIPE_STAGES=2, stream 6 back-to-back, out_ready low for cycles 2-5:
  - in_ready drops after 2 queued;
  - all 6 results emerge in order, with no loss or duplicates.
- Assert rst_n low with 2 transactions in flight and out_ready=0:
  - out_valid=0 and fp_r=0 immediately, in_ready=1;
  - first post-reset transaction has the normal latency.
